// File: rtl/mul_ctrl.sv
// mul_ctrl: issue/response controller for the two-stage pipelined
// Booth/Wallace multiplier. Accepts one request per handshake, extends the
// operands to 33-bit signed form, drives the pipeline enable and returns the
// selected product word through a valid/ready handshake.
// Optional build macro: MUL_CTRL_PERF_EN enables the issue/stall counters.
module mul_ctrl #(
  parameter int TAG_W = 4
) (
  input  logic             mul_clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_op,
  input  logic [31:0]      req_src1,
  input  logic [31:0]      req_src2,
  input  logic [TAG_W-1:0] req_tag,
  input  logic             flush,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [31:0]      resp_data,
  output logic [TAG_W-1:0] resp_tag,
  output logic             mul_do,
  output logic [32:0]      mul_a,
  output logic [32:0]      mul_b,
  input  logic [65:0]      mul_prod,
  output logic [31:0]      perf_issue_cnt,
  output logic [31:0]      perf_stall_cnt
);

  typedef enum logic [1:0] {
    OP_MUL   = 2'b00,
    OP_MULH  = 2'b01,
    OP_MULHU = 2'b10,
    OP_RSVD  = 2'b11
  } op_e;

  typedef enum logic {
    IDLE = 1'b0,
    EXEC = 1'b1
  } state_e;

  state_e           state;
  op_e              op_q;
  logic [TAG_W-1:0] tag_q;
  logic [32:0]      a_q;
  logic [32:0]      b_q;

  logic             issue;
  logic             zero_ext;
  logic [32:0]      a_ext;
  logic [32:0]      b_ext;

  // The two top product bits only carry sign information for 33x33 operands.
  logic             unused_prod_hi;
  assign unused_prod_hi = &{1'b0, mul_prod[65:64]};

  // Reset is folded in so no handshake (and no mul_do) can appear while the
  // controller is being reset, even though the FSM itself resets asynchronously.
  assign req_ready = !reset && !flush && ((state == IDLE) || resp_ready);
  assign issue     = req_valid && req_ready;
  assign mul_do    = issue;

  // Only MULH.WU treats its operands as unsigned; reserved op behaves as MUL.W.
  assign zero_ext = (op_e'(req_op) == OP_MULHU);
  assign a_ext    = {zero_ext ? 1'b0 : req_src1[31], req_src1};
  assign b_ext    = {zero_ext ? 1'b0 : req_src2[31], req_src2};

  // The multiplier sees fresh operands in the issue cycle and the held copy
  // otherwise, so its inputs never glitch while a result is being held.
  assign mul_a = issue ? a_ext : a_q;
  assign mul_b = issue ? b_ext : b_q;

  assign resp_valid = (state == EXEC) && !flush;
  assign resp_tag   = tag_q;
  assign resp_data  = ((op_q == OP_MULH) || (op_q == OP_MULHU)) ? mul_prod[63:32]
                                                                : mul_prod[31:0];

  // FSM and issue-time capture of the operation's attributes.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge mul_clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      op_q  <= OP_MUL;
      tag_q <= '0;
      a_q   <= '0;
      b_q   <= '0;
    end else begin
      if (issue) begin
        op_q  <= op_e'(req_op);
        tag_q <= req_tag;
        a_q   <= a_ext;
        b_q   <= b_ext;
      end
      case (state)
        IDLE: if (issue) state <= EXEC;
        EXEC: begin
          if (flush)           state <= IDLE;
          else if (resp_ready) state <= issue ? EXEC : IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef MUL_CTRL_PERF_EN
  logic [31:0] issue_cnt;
  logic [31:0] stall_cnt;

  // Free-running wrap-around counters of issues and backpressured cycles.
  always_ff @(posedge mul_clk or posedge reset) begin
    if (reset) begin
      issue_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      if (issue)                     issue_cnt <= issue_cnt + 32'd1;
      if (resp_valid && !resp_ready) stall_cnt <= stall_cnt + 32'd1;
    end
  end

  assign perf_issue_cnt = issue_cnt;
  assign perf_stall_cnt = stall_cnt;
`else
  assign perf_issue_cnt = '0;
  assign perf_stall_cnt = '0;
`endif

endmodule
